// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Requester, memory and stall signals of the unified memory port arbiter
//
// Signals:
//   i_cmd/i_addr            fetch request        i_done/i_rdata     fetch completion
//   d_cmd/d_addr/d_wdata    data request         d_done/d_rdata     data completion
//   mem_cmd/mem_addr/mem_wdata  memory command   mem_ack/mem_rdata  memory response
//   if_stall/mem_stall      pipeline stall indications
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters and memory)

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        i_cmd;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic [1:0]        d_cmd;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              if_stall;
    logic              mem_stall;

    modport slave (
        input  i_cmd, i_addr, d_cmd, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, mem_cmd, mem_addr, mem_wdata,
               if_stall, mem_stall
    );

    modport master (
        output i_cmd, i_addr, d_cmd, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, mem_cmd, mem_addr, mem_wdata,
               if_stall, mem_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one memory port between instruction fetch and data access
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   bus (slave)         fetch/data requests, memory command/response, stalls
//   perf_conflict_cnt   IDLE cycles with both requesters pending (MEM_PORT_ARB_PERF_EN only)
//   perf_i_wait_cnt     cycles with if_stall high (MEM_PORT_ARB_PERF_EN only)
// Optional feature macro: MEM_PORT_ARB_PERF_EN
//
// Data requests win over fetches, but after MAX_D_STREAK consecutive data
// grants made while a fetch was waiting, the fetch is granted next.

module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_i_wait_cnt
`endif
);
    localparam logic [1:0] CMD_NONE  = 2'h0;
    localparam logic [1:0] CMD_LOAD  = 2'h1;
    localparam logic [1:0] CMD_STORE = 2'h2;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              grant_i;
    logic              grant_d;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        d_streak;

    logic i_pend;
    logic d_pend;

    // Any non-zero fetch command is a load; 2'h3 on the data side is not a request.
    assign i_pend = (bus.i_cmd != CMD_NONE);
    assign d_pend = (bus.d_cmd == CMD_LOAD) || (bus.d_cmd == CMD_STORE);

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!i_pend || (d_streak < STREAK_MAX))) begin
                    grant_d    = 1'b1;
                    state_next = GNT_D;
                end else if (i_pend) begin
                    grant_i    = 1'b1;
                    state_next = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd_q    <= CMD_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            d_streak <= 4'd0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                cmd_q    <= CMD_LOAD;
                addr_q   <= bus.i_addr;
                wdata_q  <= '0;
                d_streak <= 4'd0;
            end else if (grant_d) begin
                cmd_q   <= bus.d_cmd;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                // Only grants that overtook a waiting fetch count toward the streak.
                if (i_pend) begin
                    if (d_streak != 4'hF) begin
                        d_streak <= d_streak + 4'd1;
                    end
                end else begin
                    d_streak <= 4'd0;
                end
            end else if ((state != IDLE) && bus.mem_ack) begin
                cmd_q <= CMD_NONE;
            end
        end
    end

    assign bus.mem_cmd   = cmd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Completion is reported in the ack cycle itself; an ack seen in IDLE is dropped.
    assign bus.i_done    = bus.mem_ack && (state == GNT_I);
    assign bus.d_done    = bus.mem_ack && (state == GNT_D);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    assign bus.if_stall  = i_pend && !bus.i_done;
    assign bus.mem_stall = d_pend && !bus.d_done;

`ifdef MEM_PORT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_cnt <= 32'd0;
            perf_i_wait_cnt   <= 32'd0;
        end else begin
            if ((state == IDLE) && i_pend && d_pend) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (bus.if_stall) begin
                perf_i_wait_cnt <= perf_i_wait_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_i_wait_cnt;
`endif

    mem_port_arbiter #(
        .MAX_D_STREAK(4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_PORT_ARB_PERF_EN
        ,
        .perf_conflict_cnt(perf_conflict_cnt),
        .perf_i_wait_cnt(perf_i_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.i_cmd = 2'h0;  bus.i_addr  = '0;
        bus.d_cmd = 2'h0;  bus.d_addr  = '0;  bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        step(); step();
        chk("rst_mem_cmd", 64'(bus.mem_cmd), 64'h0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        chk("rst_i_done", 64'(bus.i_done), 64'h0);
        chk("rst_d_done", 64'(bus.d_done), 64'h0);
        chk("rst_if_stall", 64'(bus.if_stall), 64'h0);
        rst = 1'b1;
        step();

        // Lone fetch, ack three cycles after mem_cmd appears
        bus.i_cmd = 2'h1; bus.i_addr = 32'h100;
        #1;
        chk("fetch_stall_req", 64'(bus.if_stall), 64'h1);
        chk("fetch_idle_cmd", 64'(bus.mem_cmd), 64'h0);
        step();
        chk("fetch_cmd", 64'(bus.mem_cmd), 64'h1);
        chk("fetch_addr", 64'(bus.mem_addr), 64'h100);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("fetch_cmd_hold", 64'(bus.mem_cmd), 64'h1);
            chk("fetch_no_done", 64'(bus.i_done), 64'h0);
            chk("fetch_stall_wait", 64'(bus.if_stall), 64'h1);
        end
        step();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("fetch_done", 64'(bus.i_done), 64'h1);
        chk("fetch_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
        chk("fetch_stall_done", 64'(bus.if_stall), 64'h0);
        chk("fetch_no_d_done", 64'(bus.d_done), 64'h0);
        step();
        bus.mem_ack = 1'b0; bus.i_cmd = 2'h0;
        #1;
        chk("fetch_after_done", 64'(bus.i_done), 64'h0);
        chk("fetch_after_cmd", 64'(bus.mem_cmd), 64'h0);

        // Store
        bus.d_cmd = 2'h2; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        #1;
        chk("store_stall_req", 64'(bus.mem_stall), 64'h1);
        step();
        chk("store_cmd", 64'(bus.mem_cmd), 64'h2);
        chk("store_addr", 64'(bus.mem_addr), 64'h200);
        chk("store_wdata", 64'(bus.mem_wdata), 64'h12345678);
        chk("store_no_done", 64'(bus.d_done), 64'h0);
        step();
        chk("store_cmd_hold", 64'(bus.mem_cmd), 64'h2);
        chk("store_wdata_hold", 64'(bus.mem_wdata), 64'h12345678);
        step();
        bus.mem_ack = 1'b1;
        #1;
        chk("store_done", 64'(bus.d_done), 64'h1);
        chk("store_stall_done", 64'(bus.mem_stall), 64'h0);
        step();
        bus.mem_ack = 1'b0; bus.d_cmd = 2'h0;
        #1;
        chk("store_after_done", 64'(bus.d_done), 64'h0);
        chk("store_after_cmd", 64'(bus.mem_cmd), 64'h0);

        // Fresh reset so the performance counters start from zero
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Simultaneous fetch and load: data first, IDLE, then fetch
        bus.i_cmd = 2'h1; bus.i_addr = 32'h300;
        bus.d_cmd = 2'h1; bus.d_addr = 32'h400;
        #1;
        chk("sim_if_stall", 64'(bus.if_stall), 64'h1);
        chk("sim_mem_stall", 64'(bus.mem_stall), 64'h1);
        step();
        chk("sim_first_addr", 64'(bus.mem_addr), 64'h400);
        chk("sim_first_cmd", 64'(bus.mem_cmd), 64'h1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA5555;
        #1;
        chk("sim_d_done", 64'(bus.d_done), 64'h1);
        chk("sim_d_rdata", 64'(bus.d_rdata), 64'hAAAA5555);
        chk("sim_i_not_done", 64'(bus.i_done), 64'h0);
        step();
        bus.mem_ack = 1'b0; bus.d_cmd = 2'h0;
        #1;
        chk("sim_idle_gap", 64'(bus.mem_cmd), 64'h0);
        step();
        chk("sim_second_addr", 64'(bus.mem_addr), 64'h300);
        chk("sim_second_cmd", 64'(bus.mem_cmd), 64'h1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
        #1;
        chk("sim_i_done", 64'(bus.i_done), 64'h1);
        chk("sim_i_rdata", 64'(bus.i_rdata), 64'h11112222);
        step();
        bus.mem_ack = 1'b0; bus.i_cmd = 2'h0;
        #1;
        chk("sim_end_cmd", 64'(bus.mem_cmd), 64'h0);
`ifdef MEM_PORT_ARB_PERF_EN
        chk("perf_conflict", 64'(perf_conflict_cnt), 64'd1);
        chk("perf_i_wait", 64'(perf_i_wait_cnt), 64'd3);
`endif

        // Starvation guard: four data grants, then one fetch, repeated
        bus.i_cmd = 2'h1; bus.i_addr = 32'h500;
        bus.d_cmd = 2'h1; bus.d_addr = 32'h600;
        #1;
        for (int g = 0; g < 10; g++) begin
            logic exp_d;
            exp_d = ((g % 5) != 4);
            step();
            chk($sformatf("starve_addr_%0d", g), 64'(bus.mem_addr), exp_d ? 64'h600 : 64'h500);
            bus.mem_ack = 1'b1;
            #1;
            chk($sformatf("starve_d_done_%0d", g), 64'(bus.d_done), 64'(exp_d));
            chk($sformatf("starve_i_done_%0d", g), 64'(bus.i_done), 64'(!exp_d));
            step();
            bus.mem_ack = 1'b0;
            #1;
            chk($sformatf("starve_idle_%0d", g), 64'(bus.mem_cmd), 64'h0);
        end
        bus.i_cmd = 2'h0; bus.d_cmd = 2'h0;

        // d_cmd of 2'h3 is not a request
        step();
        bus.d_cmd = 2'h3;
        #1;
        chk("cmd3_no_stall", 64'(bus.mem_stall), 64'h0);
        step();
        chk("cmd3_no_grant", 64'(bus.mem_cmd), 64'h0);
        bus.d_cmd = 2'h0;

        // Reset in the middle of a data grant
        bus.d_cmd = 2'h1; bus.d_addr = 32'h700;
        step();
        chk("rmid_cmd", 64'(bus.mem_cmd), 64'h1);
        step();
        rst = 1'b0;
        #1;
        chk("rmid_cmd_cleared", 64'(bus.mem_cmd), 64'h0);
        chk("rmid_addr_cleared", 64'(bus.mem_addr), 64'h0);
        chk("rmid_no_done", 64'(bus.d_done), 64'h0);
        step();
        bus.d_cmd = 2'h0;
        rst = 1'b1;
        #1;
        bus.mem_ack = 1'b1;
        #1;
        chk("rmid_late_ack", 64'(bus.d_done), 64'h0);
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("rmid_ack_no_state", 64'(bus.mem_cmd), 64'h0);
        bus.d_cmd = 2'h2; bus.d_addr = 32'h800; bus.d_wdata = 32'hCAFE0001;
        step();
        chk("rmid_new_cmd", 64'(bus.mem_cmd), 64'h2);
        chk("rmid_new_addr", 64'(bus.mem_addr), 64'h800);
        chk("rmid_new_wdata", 64'(bus.mem_wdata), 64'hCAFE0001);
        bus.mem_ack = 1'b1;
        #1;
        chk("rmid_new_done", 64'(bus.d_done), 64'h1);
        step();
        bus.mem_ack = 1'b0; bus.d_cmd = 2'h0;
        #1;
        chk("rmid_end_cmd", 64'(bus.mem_cmd), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Arbitrates between them, drives the memory command/address/data, and returns completion and read data to the winner.
- Generates stall indications for the pipeline.
- Data requests have priority; a streak limit guarantees fetch forward progress.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch must win (range 1..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_cmd  in  2  fetch command; any non-NONE value is treated as LOAD
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  fetch completion pulse
- i_rdata  out  DATA_W  fetched word, valid with i_done
- d_cmd  in  2  data command: NONE/LOAD/STORE
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  data completion pulse
- d_rdata  out  DATA_W  load data, valid with d_done
- mem_cmd  out  2  command to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion pulse, one cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- if_stall  out  1  fetch pending and not completing this cycle
- mem_stall  out  1  data access pending and not completing this cycle

Behaviour:
- Command encoding: NONE=2'h0, LOAD=2'h1, STORE=2'h2; 2'h3 on d_cmd is treated as NONE.
- Requesters hold cmd/addr/wdata stable from the cycle they assert until the cycle their done is high.
- FSM states:
  - IDLE: mem_cmd=NONE.
  - GNT_I: mem_cmd=LOAD, mem_addr=captured i_addr.
  - GNT_D: mem_cmd=captured d_cmd, addr and wdata captured.
- Command, address and write data are registered at grant time and held constant for the whole grant.
- IDLE transitions:
  - Only d pending -> GNT_D.
  - Only i pending -> GNT_I.
  - Both pending -> GNT_D if d_streak < MAX_D_STREAK, else GNT_I.
  - Neither pending -> stay IDLE.
- GNT_I / GNT_D: wait for mem_ack; the cycle mem_ack=1 -> IDLE.
- Grant latency: a request seen in IDLE at cycle N drives mem_cmd from cycle N+1.
- Completion:
  - i_done = mem_ack && state==GNT_I, combinational, same cycle as the ack; i_rdata = mem_rdata.
  - d_done likewise for GNT_D; d_rdata = mem_rdata.
  - A STORE also produces d_done; its rdata is don't-care.
- Throughput: one transaction per (memory latency + 2) cycles. Back-to-back grants always pass through one IDLE cycle.
- d_streak counter (4 bits):
  - Increments, saturating, on each GNT_D grant made while i was pending.
  - Clears on every GNT_I grant.
  - Clears on a GNT_D grant made with i not pending.
- if_stall = (i_cmd!=NONE) && !i_done. mem_stall = (d_cmd valid) && !d_done.
- mem_ack in IDLE is ignored: no done pulse, no state change.
- Reset (rst=0, any time, including mid-transaction):
  - State -> IDLE; mem_cmd=NONE; mem_addr=0; mem_wdata=0; d_streak=0.
  - i_done=0, d_done=0. i_rdata, d_rdata and stalls follow their combinational definitions (0/inputs).
  - The in-flight transaction is abandoned and its late ack is ignored.
- A requester deasserting cmd mid-grant is a protocol violation. The grant completes regardless, and the done pulse is still issued.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- When defined, adds output ports:
  - perf_conflict_cnt (32): counts IDLE cycles where both requesters are pending.
  - perf_i_wait_cnt (32): counts cycles with if_stall=1.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Lone fetch:
  - Stimulus: i_cmd=LOAD, i_addr=0x100; memory acks 3 cycles after mem_cmd appears with rdata 0xDEADBEEF.
  - Response: mem_cmd=LOAD/0x100 from the cycle after request; i_done=1 with i_rdata=0xDEADBEEF exactly in the ack cycle; if_stall=1 until then.
- Store:
  - Stimulus: d_cmd=STORE, d_addr=0x200, d_wdata=0x12345678.
  - Response: mem_cmd=STORE with those values, held until ack; d_done pulses once.
- Simultaneous:
  - Stimulus: i and d both pending from IDLE.
  - Response: data granted first; fetch granted in the grant following the data ack (IDLE in between).
- Starvation, MAX_D_STREAK=4:
  - Stimulus: i held pending; d re-requests immediately after every done.
  - Response: exactly 4 data grants, then a fetch grant, then the pattern repeats.
- Reset mid-operation:
  - Stimulus: rst=0 during GNT_D before ack.
  - Response: mem_cmd=NONE immediately; an ack arriving after release produces no d_done; a new request is granted normally.
- Perf counters (MEM_PORT_ARB_PERF_EN defined), simultaneous-request scenario:
  - Response: perf_conflict_cnt=1; perf_i_wait_cnt equals the fetch's stall cycles.
